// File: rtl/toggle_sync_multi.sv
// Multi-channel toggle/edge synchroniser living in the rd_clk domain.
// Each channel: N-flop synchroniser, edge decoder, saturating pending-event counter with pop handshake.
module toggle_sync_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int MODE        = 0
) (
    input  logic                      rd_clk,
    input  logic                      rd_reset,
    input  logic [CHANNELS-1:0]       async_in,
    output logic [CHANNELS-1:0]       sync_level,
    output logic [CHANNELS-1:0]       evt_pulse,
    output logic [CHANNELS-1:0]       evt_valid,
    input  logic [CHANNELS-1:0]       evt_ready,
    output logic [CHANNELS*CNT_W-1:0] evt_count,
    output logic [CHANNELS-1:0]       overflow,
    input  logic [CHANNELS-1:0]       ovf_clear
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] hist_q;
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [CHANNELS-1:0] inc_s;
    logic [CHANNELS-1:0] dec_s;
    logic [CHANNELS-1:0] ovf_set_s;

    // Synchroniser chain and history flop per channel
    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {CHANNELS{1'b0}};
            end
            hist_q <= {CHANNELS{1'b0}};
        end else begin
            sync_q[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

    // Edge decode: only flop outputs feed the strobe, never async_in
    always_comb begin
        if (MODE == 0) begin
            evt_pulse = sync_level ^ hist_q;
        end else begin
            evt_pulse = sync_level & ~hist_q;
        end
    end

    // Valid flags and flattened count bus, both straight from the count registers
    always_comb begin
        evt_valid = {CHANNELS{1'b0}};
        evt_count = {(CHANNELS*CNT_W){1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            evt_valid[i]                 = (cnt_q[i] != CNT_ZERO);
            evt_count[i*CNT_W +: CNT_W]  = cnt_q[i];
        end
    end

    // Counter next-state: a simultaneous push and pop cancel, and never flag overflow
    always_comb begin
        inc_s     = evt_pulse;
        dec_s     = evt_valid & evt_ready;
        ovf_set_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({inc_s[i], dec_s[i]})
                2'b10: begin
                    if (cnt_q[i] == CNT_MAX) begin
                        ovf_set_s[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                2'b01: begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
                default: begin
                    cnt_d[i] = cnt_q[i];
                end
            endcase
        end
    end

    // Sticky overflow: a new drop beats a same-cycle clear
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ovf_set_s[i]) begin
                ovf_d[i] = 1'b1;
            end else if (ovf_clear[i]) begin
                ovf_d[i] = 1'b0;
            end else begin
                ovf_d[i] = ovf_q[i];
            end
        end
    end

    // Counter and overflow registers
    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            ovf_q <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_toggle_sync_multi.sv
// Randomised scoreboard bench: a toggle-mode instance (3-bit counters) and a rising-edge instance
// (2-bit counters) share stimulus and are checked against a delay-line/event-count model.
module tb_toggle_sync_multi;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int W0 = 3;
    localparam int W1 = 2;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst_n;
    logic [CH-1:0] ain, rdy, clr;
    logic [CH-1:0] lvl0, pul0, val0, ovf0, lvl1, pul1, val1, ovf1;
    logic [CH*W0-1:0] cnt0;
    logic [CH*W1-1:0] cnt1;

    always #5 clk = ~clk;

    toggle_sync_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(W0), .MODE(0)) u_dut0 (
        .rd_clk(clk), .rd_reset(rst_n), .async_in(ain), .sync_level(lvl0), .evt_pulse(pul0),
        .evt_valid(val0), .evt_ready(rdy), .evt_count(cnt0), .overflow(ovf0), .ovf_clear(clr)
    );

    toggle_sync_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(W1), .MODE(1)) u_dut1 (
        .rd_clk(clk), .rd_reset(rst_n), .async_in(ain), .sync_level(lvl1), .evt_pulse(pul1),
        .evt_valid(val1), .evt_ready(rdy), .evt_count(cnt1), .overflow(ovf1), .ovf_clear(clr)
    );

    typedef struct {
        logic [CH-1:0]    lvl, p0, v0, o0, p1, v1, o1;
        logic [CH*W0-1:0] c0;
        logic [CH*W1-1:0] c1;
    } snap_t;

    snap_t sbq[$];
    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    // Reference model: an input delay line plus integer event counters per instance
    logic [CH-1:0] m_pipe[$];
    logic [CH-1:0] m_lvl, m_hist;
    int m_cnt[2][CH];
    bit m_ovf[2][CH];
    int m_max[2] = '{7, 3};

    int tog_tab[4] = '{0, 5, 30, 60};
    int rdy_tab[4] = '{0, 20, 60, 100};
    int clr_tab[3] = '{0, 2, 10};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        for (int k = 0; k < SS; k++) m_pipe.push_back('0);
        m_lvl  = '0;
        m_hist = '0;
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < CH; c++) begin
                m_cnt[n][c] = 0;
                m_ovf[n][c] = 1'b0;
            end
    endtask

    task automatic model_step(input logic [CH-1:0] a, input logic [CH-1:0] r, input logic [CH-1:0] cl);
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < CH; c++) begin
                bit ev, pop, drop;
                ev   = (n == 0) ? (m_lvl[c] != m_hist[c]) : (m_lvl[c] && !m_hist[c]);
                pop  = (m_cnt[n][c] > 0) && r[c];
                drop = 1'b0;
                if (ev && !pop) begin
                    if (m_cnt[n][c] == m_max[n]) drop = 1'b1;
                    else m_cnt[n][c]++;
                end else if (pop && !ev) begin
                    m_cnt[n][c]--;
                end
                if (drop) m_ovf[n][c] = 1'b1;
                else if (cl[c]) m_ovf[n][c] = 1'b0;
            end
        end
        m_hist = m_lvl;
        m_pipe.push_back(a);
        void'(m_pipe.pop_front());
        m_lvl = m_pipe[0];
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s = '{default: '0};
        s.lvl = m_lvl;
        for (int c = 0; c < CH; c++) begin
            s.p0[c] = m_lvl[c] != m_hist[c];
            s.p1[c] = m_lvl[c] && !m_hist[c];
            s.v0[c] = m_cnt[0][c] != 0;
            s.v1[c] = m_cnt[1][c] != 0;
            s.o0[c] = m_ovf[0][c];
            s.o1[c] = m_ovf[1][c];
            s.c0[c*W0 +: W0] = W0'(m_cnt[0][c]);
            s.c1[c*W1 +: W1] = W1'(m_cnt[1][c]);
        end
        return s;
    endfunction

    // Monitor: one expected snapshot is consumed per rd_clk edge
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #2;
            if (started) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=0 expected=1 at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("sync_level_m0", 64'(lvl0), 64'(e.lvl));
                    chk("sync_level_m1", 64'(lvl1), 64'(e.lvl));
                    chk("evt_pulse_m0",  64'(pul0), 64'(e.p0));
                    chk("evt_pulse_m1",  64'(pul1), 64'(e.p1));
                    chk("evt_valid_m0",  64'(val0), 64'(e.v0));
                    chk("evt_valid_m1",  64'(val1), 64'(e.v1));
                    chk("evt_count_m0",  64'(cnt0), 64'(e.c0));
                    chk("evt_count_m1",  64'(cnt1), 64'(e.c1));
                    chk("overflow_m0",   64'(ovf0), 64'(e.o0));
                    chk("overflow_m1",   64'(ovf1), 64'(e.o1));
                end
            end
        end
    end

    // Stimulus: randomised phases, with two mid-run resets while async_in holds 4'b1010
    initial begin
        int tog_p, rdy_p, clr_p;
        bit in_rst, hold1010;
        rst_n = 1'b0;
        ain = '0;
        rdy = '0;
        clr = '0;
        tog_p = 0;
        rdy_p = 0;
        clr_p = 0;
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc % 150 == 0) begin
                tog_p = tog_tab[$urandom_range(3)];
                rdy_p = rdy_tab[$urandom_range(3)];
                clr_p = clr_tab[$urandom_range(2)];
            end
            in_rst   = (cyc < 3) || (cyc >= 1000 && cyc < 1003) || (cyc >= 2000 && cyc < 2004);
            hold1010 = (cyc >= 995 && cyc < 1015) || (cyc >= 1995 && cyc < 2015);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(99) < tog_p) ain[c] = ~ain[c];
                rdy[c] = ($urandom_range(99) < rdy_p);
                clr[c] = ($urandom_range(99) < clr_p);
            end
            if (hold1010) begin
                ain = 4'b1010;
                rdy = 4'b0000;
            end
            if (in_rst) begin
                if (rst_n) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_async_m0", 64'({lvl0, pul0, val0, ovf0, cnt0}), 64'd0);
                    chk("rst_async_m1", 64'({lvl1, pul1, val1, ovf1, cnt1}), 64'd0);
                end
                model_reset();
            end else begin
                rst_n = 1'b1;
                model_step(ain, rdy, clr);
            end
            sbq.push_back(model_snap());
            started = 1'b1;
        end
        @(posedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
